mem_wb_stage: RTL
=================

# mem_wb_stage

MEM/WB pipeline register and write-back stage of the MIPS pipeline. Captures the memory-stage outputs (load data, ALU result, destination register, control) on each clock. Applies load-size extraction and sign/zero extension, then selects the write-back value. Drives the register-file write port and the forwarding/hazard unit.

## Interface
Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_stall  in  1  hold current MEM/WB contents.
- i_flush  in  1  load a bubble instead of the incoming entry.
- i_valid  in  1  incoming MEM entry is a real instruction.
- i_read_data  in  DATA_W  load data; byte at address is [7:0], little-endian.
- i_alu_result  in  DATA_W  ALU result / effective address.
- i_rd  in  REG_AW  destination register.
- i_mem_to_reg  in  1  1 = write-back from load data, 0 = from ALU result.
- i_reg_write  in  1  instruction writes the register file.
- i_load_size  in  2  00 byte, 01 halfword, 10 word, 11 word.
- i_load_unsigned  in  1  1 = zero-extend, 0 = sign-extend (byte/half only).
- o_wb_valid  out  1  registered entry is valid.
- o_wb_we  out  1  register-file write enable.
- o_wb_rd  out  REG_AW  register-file write address.
- o_wb_data  out  DATA_W  register-file write data; also the forwarding value.
- o_retired  out  32  retired-instruction count; present only with WB_RETIRE_COUNT_EN.

## Operation
- Extension is combinational on the inputs, before the register:
  - byte: {24{s&b[7]}, b[7:0]};
  - half: {16{s&h[15]}, h[15:0]};
  - word: unchanged;
  - s = ~i_load_unsigned.
- Next write-back data = i_mem_to_reg ? extended load : i_alu_result; latched into the data register.
- Register update priority:
  - i_flush: valid, mem_to_reg, reg_write and rd are cleared; data is don't-care and is cleared to 0.
  - else i_stall: all fields held.
  - else: all fields loaded from the inputs.
- o_wb_we = valid & reg_write & (rd != 0). Register 0 is never written.
- o_wb_rd and o_wb_data come straight from the register, with no output logic besides the o_wb_we gate.
- Flush and stall together: flush wins; a bubble is loaded.
- The extension path ignores i_load_size/i_load_unsigned when i_mem_to_reg=0.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- The register-file write occurs at edge N+1 and is performed by the register file.
- Reset (asynchronous): o_wb_valid=0, o_wb_we=0, o_wb_rd=0, o_wb_data=0, o_retired=0, immediately and independent of the clock.
- Deassertion takes effect at the next rising edge.
- Reset mid-stall discards the held entry.
- A stall holds o_wb_we asserted if it was asserted. The register file sees repeated identical writes, which are harmless.
- No handshake: i_stall/i_flush come from the hazard unit and must be stable before the edge.

## Configuration
- WB_RETIRE_COUNT_EN defined:
  - o_retired exists.
  - 32-bit counter increments at each edge where the register loads an entry with i_valid=1 (not flush, not stall).
  - Wraps 0xFFFFFFFF -> 0.
  - Cleared only by reset.
- Undefined: port and counter are absent; no other behaviour changes.

## Structure
- Shared package mips_pkg holds the load-size encodings LS_BYTE=2'b00, LS_HALF=2'b01, LS_WORD=2'b10, plus DATA_W/REG_AW defaults.
- One sub-module, load_extend, is purely combinational: data, size, unsigned -> extended word.
- Register, priority logic and counter live in mem_wb_stage.

## Test plan
- Reset: assert i_reset mid-cycle with a valid entry loaded -> all outputs 0 immediately; o_retired=0.
- Signed byte load: read_data=0x123456F0, size=00, unsigned=0, mem_to_reg=1, rd=5, reg_write=1 -> next cycle o_wb_data=0xFFFFFFF0, o_wb_we=1, o_wb_rd=5.
- Loads, other sizes:
  - half unsigned 0x0000_8001 -> 0x00008001;
  - half signed -> 0xFFFF8001;
  - word 0xDEADBEEF -> 0xDEADBEEF.
- ALU path and r0:
  - mem_to_reg=0, alu_result=0x00000040, rd=0, reg_write=1 -> o_wb_data=0x40, o_wb_we=0;
  - same with rd=3 -> o_wb_we=1.
- Stall/flush:
  - load entry A (rd=7, data 0x11), stall 3 cycles with new inputs -> outputs stay A;
  - stall+flush -> o_wb_valid=0, o_wb_we=0, o_wb_data=0.
- Counter (macro on): 10 valid entries, 2 stalled cycles, 1 flush -> o_retired=10; preload near wrap via 2^32 entries is impractical, so force counter to 0xFFFFFFFF and retire one -> 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: load-size encodings and datapath defaults.
package mips_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;
endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: memory-stage entry in, register-file write port out.
// o_retired exists only when WB_RETIRE_COUNT_EN is defined.
interface mem_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              i_stall;
  logic              i_flush;
  logic              i_valid;
  logic [DATA_W-1:0] i_read_data;
  logic [DATA_W-1:0] i_alu_result;
  logic [REG_AW-1:0] i_rd;
  logic              i_mem_to_reg;
  logic              i_reg_write;
  logic [1:0]        i_load_size;
  logic              i_load_unsigned;
  logic              o_wb_valid;
  logic              o_wb_we;
  logic [REG_AW-1:0] o_wb_rd;
  logic [DATA_W-1:0] o_wb_data;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0]       o_retired;
`endif

  modport master (
    output i_stall, i_flush, i_valid, i_read_data, i_alu_result, i_rd,
           i_mem_to_reg, i_reg_write, i_load_size, i_load_unsigned,
    input  o_wb_valid, o_wb_we, o_wb_rd, o_wb_data
`ifdef WB_RETIRE_COUNT_EN
    , input o_retired
`endif
  );

  modport slave (
    input  i_stall, i_flush, i_valid, i_read_data, i_alu_result, i_rd,
           i_mem_to_reg, i_reg_write, i_load_size, i_load_unsigned,
    output o_wb_valid, o_wb_we, o_wb_rd, o_wb_data
`ifdef WB_RETIRE_COUNT_EN
    , output o_retired
`endif
  );
endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// Combinational load extraction: picks byte/half/word at offset 0 and
// sign- or zero-extends it to the full datapath width.
module load_extend
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_data
);
  logic       w_s;
  logic [7:0] w_b;
  logic [15:0] w_h;

  assign w_s = ~i_unsigned;
  assign w_b = i_data[7:0];
  assign w_h = i_data[15:0];

  always_comb begin
    o_data = i_data;
    case (i_size)
      LS_BYTE: o_data = {{(DATA_W-8){w_s & w_b[7]}}, w_b};
      LS_HALF: o_data = {{(DATA_W-16){w_s & w_h[15]}}, w_h};
      default: o_data = i_data;
    endcase
  end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back select for the MIPS pipeline.
// Optional retired-instruction counter under WB_RETIRE_COUNT_EN.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic         i_clk,
  input  logic         i_reset,
  mem_wb_stage_if.slave bus
);
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_wb_next;
  logic              w_load;

  logic              r_valid;
  logic              r_reg_write;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_data;

  load_extend #(.DATA_W(DATA_W)) u_ext (
    .i_data     (bus.i_read_data),
    .i_size     (bus.i_load_size),
    .i_unsigned (bus.i_load_unsigned),
    .o_data     (w_ext)
  );

  assign w_wb_next = bus.i_mem_to_reg ? w_ext : bus.i_alu_result;
  assign w_load    = ~bus.i_flush & ~bus.i_stall;

  // Flush beats stall: a bubble is loaded even while the stage is held.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_data      <= '0;
    end else if (bus.i_flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_data      <= '0;
    end else if (w_load) begin
      r_valid     <= bus.i_valid;
      r_reg_write <= bus.i_reg_write;
      r_rd        <= bus.i_rd;
      r_data      <= w_wb_next;
    end
  end

  assign bus.o_wb_valid = r_valid;
  assign bus.o_wb_we    = r_valid & r_reg_write & (r_rd != '0);
  assign bus.o_wb_rd    = r_rd;
  assign bus.o_wb_data  = r_data;

`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] r_retired;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_retired <= '0;
    else if (w_load && bus.i_valid)
      r_retired <= r_retired + 32'd1;
  end

  assign bus.o_retired = r_retired;
`endif
endmodule
